fft_bitrev_reorder: RTL and testbench
=====================================

# fft_bitrev_reorder

Output-side reorder buffer for the FFT datapath. Accepts a stream of packed complex words from the last butterfly stage in bit-reversed index order and emits each frame of N words in natural index order. Ping-pong double buffering lets frame k+1 be written while frame k drains.

## Interface
- `WORD_SZ`, 8: packed complex word width. Real part is in [WORD_SZ-1:WORD_SZ/2]; imaginary part is in [WORD_SZ/2-1:0].
- `LOG2_N`, 3: log2 of the frame length. N = 2**LOG2_N.
- `i_CLK` input 1: single clock, rising edge.
- `i_RESET` input 1: asynchronous, active-high reset.
- `i_valid` input 1: the upstream word is valid.
- `i_data` input WORD_SZ: upstream word, bit-reversed order.
- `o_ready` output 1: the buffer can accept the upstream word this cycle.
- `o_valid` output 1: the output word is valid.
- `o_data` output WORD_SZ: output word, natural order.
- `o_last` output 1: the output word is index N-1 of its frame.
- `i_ready` input 1: the downstream side accepts `o_data` this cycle.

## Operation
- Storage is two banks, each holding N words. Each bank has a `full` flag.
- Pointers: `wr_bank`, `rd_bank` (1 bit each); `wr_cnt`, `rd_cnt` (LOG2_N bits each).
- Input transfer condition: `i_valid && o_ready`.
  - `mem[wr_bank][bitrev(wr_cnt)] <= i_data`.
  - `wr_cnt` increments and wraps N-1 -> 0.
  - When the transfer has `wr_cnt == N-1`: set `full[wr_bank]` and toggle `wr_bank`.
- `o_ready = !full[wr_bank]`.
- `o_valid = full[rd_bank]`.
- `o_data = mem[rd_bank][rd_cnt]` when `o_valid`, else 0.
- `o_last = o_valid && (rd_cnt == N-1)`.
- Output transfer condition: `o_valid && i_ready`.
  - `rd_cnt` increments and wraps.
  - When the transfer has `rd_cnt == N-1`: clear `full[rd_bank]` and toggle `rd_bank`.
- Each bank cycles through EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
  - EMPTY -> FILLING: first write.
  - FILLING -> FULL: N-th write.
  - FULL -> DRAINING: first read.
  - DRAINING -> EMPTY: N-th read.
  - The `full` flag is the only state stored. FILLING and DRAINING are implied by the counters.
- Data is carried unmodified: no arithmetic and no width change. `bitrev` reverses the LOG2_N bits of the counter.
- Boundary conditions:
  - Both banks full: `o_ready` is 0 and upstream stalls. No word is ever overwritten or dropped.
  - Both banks empty: `o_valid` is 0 and `o_data` is 0.
  - Same cycle, one bank completes a fill while the other completes a drain: both take effect. Flags and bank pointers update independently.
  - `i_valid` while `o_ready` is 0: ignored. No state changes.
  - `i_ready` while `o_valid` is 0: ignored.
  - Reset mid-frame: pointers, counters and flags clear immediately. The partial frame is discarded. Bank contents are not reset.

## Timing
- Reset values:
  - `o_valid` 0, `o_last` 0, `o_data` 0.
  - `o_ready` 1.
  - `wr_bank`, `rd_bank`, `wr_cnt`, `rd_cnt` all 0.
  - `full` flags 0.
- Latency: `o_valid` rises in the cycle after the N-th input transfer of a frame.
  - That is 1 clock after the last accepted word.
  - It is N clocks after the first word when input runs at full rate.
- Throughput: one word per cycle in each direction at the same time, with no bubbles across frame boundaries while both sides keep streaming.
- `o_data`, `o_valid` and `o_last` depend only on registers. There is no combinational path from `i_ready` or `i_valid` to any output.

## Structure
- Shared package `fft_pkg` holds:
  - `WORD_SZ` default.
  - `LOG2_N` default.
  - The `bitrev` function (LOG2_N-bit reversal), also used by future FFT address generators.
- Sub-module `fft_reorder_bank` is one N-word register bank.
  - Inputs: write enable, write address, write data. Reads are combinational.
  - It is instantiated twice. Control stays in the top module.

## Test plan
- **Single frame, N=8.** After reset, send `8'h00,8'h40,8'h20,8'h60,8'h10,8'h50,8'h30,8'h70` back-to-back with `i_ready` held at 1.
  - Expect `8'h00,8'h10,...,8'h70` on consecutive cycles.
  - First output appears 1 cycle after the last input.
  - `o_last` is high only with `8'h70`.
- **Continuous streaming.** Send 4 frames back-to-back, with the same pattern plus a frame tag in the imaginary nibble.
  - Expect `o_ready` stays 1 throughout.
  - Expect 32 natural-order outputs with no gaps.
- **Backpressure.** Hold `i_ready` at 0 while 3 frames are sent.
  - Expect `o_ready` drops to 0 after the 16th accepted word.
  - Release `i_ready`: expect frames 1 and 2 out intact, then frame 3 accepted.
- **Simultaneous boundary.** Time the 8th write to bank 1 and the 8th read from bank 0 into the same cycle.
  - Expect `full` to be 2'b10 afterward and `rd_bank` = 1.
- **Reset mid-frame.** Assert `i_RESET` after 5 words of frame 2 while frame 1 is draining.
  - Expect `o_valid` goes to 0 at once and `o_ready` to 1.
  - A fresh frame then passes correctly.
- **Idle handshakes.** Drive `i_valid` at 0 with `i_ready` at 1 for 20 cycles.
  - Expect `o_valid` stays 0, `o_data` stays 0, and the counters do not move.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT defaults and the bit-reversal helper used by address generators
package fft_pkg;
  localparam int DEF_WORD_SZ = 8;
  localparam int DEF_LOG2_N = 3;
  function automatic logic [31:0] bitrev(input logic [31:0] a, input int w);
    bitrev = '0;
    for (int i = 0; i < w; i++) bitrev[i] = a[w-1-i];
  endfunction
endpackage

// File: rtl/fft_reorder_bank.sv
// fft_reorder_bank: one N-word register bank, synchronous write, combinational read
// ports: clk clock; we/waddr/wdata write port; raddr/rdata combinational read port
module fft_reorder_bank
  import fft_pkg::*;
#(
  parameter int WORD_SZ = DEF_WORD_SZ,
  parameter int LOG2_N = DEF_LOG2_N
) (
  input  logic               clk,
  input  logic               we,
  input  logic [LOG2_N-1:0]  waddr,
  input  logic [WORD_SZ-1:0] wdata,
  input  logic [LOG2_N-1:0]  raddr,
  output logic [WORD_SZ-1:0] rdata
);
  logic [WORD_SZ-1:0] mem [2**LOG2_N];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong buffer turning bit-reversed FFT frames into natural order
// ports: i_CLK clock, i_RESET async active-high reset;
//        i_valid/i_data/o_ready upstream stream in bit-reversed order;
//        o_valid/o_data/o_last/i_ready downstream stream in natural order, o_last on index N-1
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int WORD_SZ = DEF_WORD_SZ,
  parameter int LOG2_N = DEF_LOG2_N
) (
  input  logic               i_CLK,
  input  logic               i_RESET,
  input  logic               i_valid,
  input  logic [WORD_SZ-1:0] i_data,
  output logic               o_ready,
  output logic               o_valid,
  output logic [WORD_SZ-1:0] o_data,
  output logic               o_last,
  input  logic               i_ready
);
  localparam logic [LOG2_N-1:0] LAST = '1;
  logic [1:0] full;
  logic wr_bank, rd_bank, wr_fire, rd_fire, wr_done, rd_done;
  logic [LOG2_N-1:0] wr_cnt, rd_cnt, wr_addr;
  logic [WORD_SZ-1:0] rdata [2];
  assign o_ready = !full[wr_bank];
  assign o_valid = full[rd_bank];
  assign o_data = o_valid ? rdata[rd_bank] : '0;
  assign o_last = o_valid && rd_cnt == LAST;
  assign wr_fire = i_valid && o_ready;
  assign rd_fire = o_valid && i_ready;
  assign wr_done = wr_fire && wr_cnt == LAST;
  assign rd_done = rd_fire && rd_cnt == LAST;
  // words land at their natural index so the drain side just counts up
  assign wr_addr = LOG2_N'(bitrev(32'(wr_cnt), LOG2_N));
  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_reorder_bank #(.WORD_SZ(WORD_SZ), .LOG2_N(LOG2_N)) u_bank (
      .clk(i_CLK),
      .we(wr_fire && wr_bank == 1'(b)),
      .waddr(wr_addr),
      .wdata(i_data),
      .raddr(rd_cnt),
      .rdata(rdata[b])
    );
  end
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      full <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (wr_fire) wr_cnt <= wr_cnt + 1'b1;
      if (rd_fire) rd_cnt <= rd_cnt + 1'b1;
      if (wr_done) wr_bank <= !wr_bank;
      if (rd_done) rd_bank <= !rd_bank;
      // fill and drain always target different banks, so set and clear never collide
      full <= (full | (wr_done ? 2'b01 << wr_bank : 2'b00)) & ~(rd_done ? 2'b01 << rd_bank : 2'b00);
    end
  end
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb_fft_bitrev_reorder: scoreboard bench for the bit-reversal reorder buffer
module tb_fft_bitrev_reorder;
  logic clk = 0, rst = 1, i_valid = 0, i_ready = 0;
  logic [7:0] i_data = 0;
  logic o_ready, o_valid, o_last;
  logic [7:0] o_data;
  localparam logic [7:0] BR [8] = '{8'h00, 8'h40, 8'h20, 8'h60, 8'h10, 8'h50, 8'h30, 8'h70};
  localparam logic [7:0] NAT [8] = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70};
  logic [8:0] expq [$];
  logic [8:0] mon_e;
  int n_vec = 0, n_err = 0, cyc = 0, prev = -1, g = 0;
  bit gap_chk = 0, stall_chk = 0, f3_done = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  fft_bitrev_reorder dut (
    .i_CLK(clk), .i_RESET(rst), .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
    .o_valid(o_valid), .o_data(o_data), .o_last(o_last), .i_ready(i_ready)
  );
  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
    end
  endfunction
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) begin
      if (expq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: got %0h want nothing at t=%0t", o_data, $time);
      end else begin
        mon_e = expq.pop_front();
        check("out", {23'b0, o_last, o_data}, {23'b0, mon_e});
      end
      if (gap_chk) begin
        if (prev >= 0) check("gap", cyc - prev, 1);
        prev = cyc;
      end
    end
  end
  task automatic send_word(input logic [7:0] d);
    int tries = 0;
    bit acc = 0;
    i_valid = 1;
    i_data = d;
    while (!acc && tries < 200) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    i_valid = 0;
    if (!acc) check("accept_timeout", 0, 1);
    else if (stall_chk) check("stream_rdy", tries, 1);
  endtask
  task automatic send_frame(input logic [3:0] t, input int n);
    for (int k = 0; k < n; k++) send_word(BR[k] | {4'h0, t});
    if (n == 8) for (int j = 0; j < 8; j++) expq.push_back({1'(j == 7), NAT[j] | {4'h0, t}});
  endtask
  task automatic drain();
    int w = 0;
    while (expq.size() != 0 && w < 300) begin
      @(posedge clk);
      w++;
    end
    #1;
    if (expq.size() != 0) check("drain_timeout", expq.size(), 0);
  endtask
  task automatic apply_reset();
    rst = 1;
    expq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout at t=%0t", $time);
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_ready", o_ready, 1);
    check("rst_data", o_data, 0);
    check("rst_last", o_last, 0);
    check("rst_full", dut.full, 0);
    rst = 0;
    i_ready = 1;
    send_frame(4'h0, 8);
    check("lat_valid", o_valid, 1);
    drain();
    gap_chk = 1;
    prev = -1;
    stall_chk = 1;
    for (int f = 1; f <= 4; f++) send_frame(4'(f), 8);
    stall_chk = 0;
    drain();
    gap_chk = 0;
    @(posedge clk);
    #1 i_ready = 0;
    send_frame(4'h5, 8);
    send_frame(4'h6, 8);
    @(negedge clk);
    check("bp_ready", o_ready, 0);
    check("bp_full", dut.full, 2'b11);
    fork
      begin
        send_frame(4'h7, 8);
        f3_done = 1;
      end
    join_none
    repeat (4) @(negedge clk);
    check("bp_hold", o_ready, 0);
    @(posedge clk);
    #1 i_ready = 1;
    g = 0;
    while (!f3_done && g < 300) begin
      @(posedge clk);
      g++;
    end
    check("bp_frame3", f3_done, 1);
    drain();
    apply_reset();
    i_ready = 0;
    send_frame(4'h8, 8);
    i_ready = 1;
    send_frame(4'h9, 8);
    check("sim_full", dut.full, 2'b10);
    check("sim_rdbank", dut.rd_bank, 1);
    check("sim_wrbank", dut.wr_bank, 0);
    drain();
    apply_reset();
    i_ready = 0;
    send_frame(4'hA, 8);
    i_ready = 1;
    send_frame(4'hB, 5);
    #1 rst = 1;
    #1;
    check("mid_valid", o_valid, 0);
    check("mid_ready", o_ready, 1);
    check("mid_data", o_data, 0);
    check("mid_wrcnt", dut.wr_cnt, 0);
    expq.delete();
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    send_frame(4'hC, 8);
    drain();
    i_ready = 1;
    repeat (20) begin
      @(negedge clk);
      check("idle_valid", o_valid, 0);
      check("idle_data", o_data, 0);
    end
    check("idle_wrcnt", dut.wr_cnt, 0);
    check("idle_rdcnt", dut.rd_cnt, 0);
    check("idle_wrbank", dut.wr_bank, 1);
    check("idle_rdbank", dut.rd_bank, 1);
    check("idle_ready", o_ready, 1);
    check("q_empty", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
